operand_fetch_stage: RTL

Decode/operand-fetch stage that sits directly upstream of the 64-bit ALU. It holds the 32×64 integer register file, decodes the rs1/rs2 fields of each RV64 R-type instruction, and registers the operand pair `a`/`b` plus the instruction word onto the ALU inputs. It accepts instructions with a valid/ready handshake. A single write-back port returns ALU results into the register file, with same-cycle bypass.

---
 rtl/operand_fetch_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage feeding the 64-bit ALU. It owns the 32-entry integer register file
// and registers the rs1/rs2 operands and the instruction word onto the ALU inputs. There
// is one write-back port, and its data is bypassed into an operand captured on the same edge.
module operand_fetch_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instruction,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [31:0]     instruction,
    output logic            illegal
);

    localparam logic [6:0] OpcodeRType = 7'b0110011;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] rf_q [NREGS];

    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [31:0]     instr_q, instr_d;
    logic            illegal_q, illegal_d;

    logic            wb_hit;
    logic            accept;
    logic            drain;
    logic            stalled;
    logic [4:0]      in_rs1, in_rs2;
    logic [4:0]      held_rs1, held_rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;

    // Field decode of the incoming instruction and of the instruction held on the outputs
    assign in_rs1   = in_instruction[19:15];
    assign in_rs2   = in_instruction[24:20];
    assign held_rs1 = instr_q[19:15];
    assign held_rs2 = instr_q[24:20];

    // A write-back to x0 is dropped everywhere, including in the bypass paths
    assign wb_hit = wb_en && (wb_rd != 5'd0);

    assign out_valid = (state_q == StFull);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign stalled   = out_valid && !out_ready;

    // Register file write port; the whole array clears on reset and x0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_hit) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // Operand read with same-edge write-back bypass; x0 always reads as zero
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (in_rs1 != 5'd0) begin
            rs1_val = (wb_hit && (wb_rd == in_rs1)) ? wb_data : rf_q[in_rs1];
        end
        if (in_rs2 != 5'd0) begin
            rs2_val = (wb_hit && (wb_rd == in_rs2)) ? wb_data : rf_q[in_rs2];
        end
    end

    // Output datapath: load on accept, refresh held operands from write-back while stalled
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        if (flush) begin
            // Held values are kept; only the valid bit drops
        end else if (accept) begin
            a_d       = rs1_val;
            b_d       = rs2_val;
            instr_d   = in_instruction;
            illegal_d = (in_instruction[6:0] != OpcodeRType);
        end else if (stalled && wb_hit) begin
            // Both operands may update when rs1 == rs2
            if (wb_rd == held_rs1) begin
                a_d = wb_data;
            end
            if (wb_rd == held_rs2) begin
                b_d = wb_data;
            end
        end
    end

    // Valid-state next-state logic; priority is flush, then accept, then drain
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (!flush && accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (flush) begin
                    state_d = StEmpty;
                end else if (accept) begin
                    state_d = StFull;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StEmpty;
            a_q       <= '0;
            b_q       <= '0;
            instr_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign instruction = instr_q;
    assign illegal     = illegal_q;

endmodule
